wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 35 +++
 rtl/wb_fifo2.sv | 82 ++++++++
 rtl/wb_stage.sv | 189 ++++++++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// =============================================================================
// Module      : wb_stage_pkg
// Description : Shared widths, condition-code bit positions and FIFO state
//               encoding for the writeback stage.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package wb_stage_pkg;

    // Default datapath widths used by the writeback stage parameters
    localparam int DEF_REG_WIDTH     = 16;
    localparam int DEF_VREG_WIDTH    = 64;
    localparam int DEF_VREG_ID_WIDTH = 3;
    localparam int DEF_PC_WIDTH      = 16;
    localparam int DEF_NUM_RF        = 16;

    // Retirement buffer depth (the FIFO sub-module is built for exactly two)
    localparam int WB_FIFO_DEPTH = 2;

    // Bit positions inside the {N,Z,P} condition-code vector
    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    // Occupancy of the two-entry retirement FIFO
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_fifo2.sv
// =============================================================================
// Module      : wb_fifo2
// Description : Two-entry shifting FIFO. Entry 0 is always the head, so both
//               stored entries and their valid bits can be exposed directly.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_fifo2
    import wb_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [1:0]       valid_o,
    output logic [WIDTH-1:0] entry0_o,
    output logic [WIDTH-1:0] entry1_o
);

    fifo_state_e      state_q, state_d;
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;

    // State and storage registers; reset discards anything buffered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FIFO_EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            state_q  <= state_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    // Next occupancy and entry contents; a pop shifts entry 1 into the head
    always_comb begin
        state_d  = state_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        unique case (state_q)
            FIFO_EMPTY: begin
                if (push_i) begin
                    entry0_d = data_i;
                    state_d  = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                if (push_i && pop_i) begin
                    entry0_d = data_i;
                end else if (push_i) begin
                    entry1_d = data_i;
                    state_d  = FIFO_FULL;
                end else if (pop_i) begin
                    state_d  = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                // A full FIFO never accepts, so only a pop is honoured here
                if (pop_i) begin
                    entry0_d = entry1_q;
                    state_d  = FIFO_ONE;
                end
            end
            default: state_d = FIFO_EMPTY;
        endcase
    end

    assign full_o   = (state_q == FIFO_FULL);
    assign valid_o  = {state_q == FIFO_FULL, state_q != FIFO_EMPTY};
    assign entry0_o = entry0_q;
    assign entry1_o = entry1_q;

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// =============================================================================
// Module      : wb_stage
// Description : Writeback stage. Buffers completed MEM bundles, retires one per
//               unstalled cycle as single-cycle write pulses, and publishes the
//               destinations still waiting in the buffer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int REG_WIDTH     = DEF_REG_WIDTH,
    parameter int VREG_WIDTH    = DEF_VREG_WIDTH,
    parameter int VREG_ID_WIDTH = DEF_VREG_ID_WIDTH,
    parameter int PC_WIDTH      = DEF_PC_WIDTH,
    parameter int NUM_RF        = DEF_NUM_RF
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_MW_Valid,
    output logic                     O_MW_Ready,
    input  logic [3:0]               I_MW_DestRegIdx,
    input  logic                     I_MW_DestWrite,
    input  logic [VREG_ID_WIDTH-1:0] I_MW_DestVRegIdx,
    input  logic                     I_MW_DestVWrite,
    input  logic [REG_WIDTH-1:0]     I_MW_Data,
    input  logic [VREG_WIDTH-1:0]    I_MW_VecData,
    input  logic [VREG_WIDTH-1:0]    I_MW_VecOld,
    input  logic [3:0]               I_MW_CompMask,
    input  logic                     I_MW_CCWEn,
    input  logic                     I_MW_PCEn,
    input  logic [PC_WIDTH-1:0]      I_MW_PC,
    input  logic                     I_GPUStallSignal,
    output logic [3:0]               O_WriteBackRegIdx,
    output logic [REG_WIDTH-1:0]     O_WriteBackData,
    output logic                     O_RegWEn,
    output logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx,
    output logic [VREG_WIDTH-1:0]    O_VecDestValue,
    output logic                     O_VRegWEn,
    output logic [2:0]               O_CCValue,
    output logic                     O_CCWEn,
    output logic [PC_WIDTH-1:0]      O_WriteBackPC,
    output logic                     O_WriteBackPCEn,
    output logic [NUM_RF-1:0]        O_WBPendMask,
    output logic                     O_WBPendVWrite,
    output logic [31:0]              O_RetireCount
);

    localparam int COMP_W = VREG_WIDTH / 4;

    // One buffered bundle, with merge and CC already resolved at accept time
    typedef struct packed {
        logic [3:0]               dest_reg;
        logic                     dest_write;
        logic [VREG_ID_WIDTH-1:0] dest_vreg;
        logic                     dest_vwrite;
        logic [REG_WIDTH-1:0]     data;
        logic [VREG_WIDTH-1:0]    vec;
        logic [2:0]               cc;
        logic                     cc_wen;
        logic                     pc_en;
        logic [PC_WIDTH-1:0]      pc;
    } entry_t;

    entry_t                  w_in, w_head, w_tail;
    logic [1:0]              w_valid;
    logic                    w_full, w_push, w_pop, w_unused;
    logic [VREG_WIDTH-1:0]   w_merged;
    logic [2:0]              w_cc;

    logic [3:0]               regidx_q;
    logic [REG_WIDTH-1:0]     data_q;
    logic                     regwen_q;
    logic [VREG_ID_WIDTH-1:0] vregidx_q;
    logic [VREG_WIDTH-1:0]    vec_q;
    logic                     vregwen_q;
    logic [2:0]               cc_q;
    logic                     ccwen_q;
    logic [PC_WIDTH-1:0]      pc_q;
    logic                     pcen_q;
    logic [31:0]              count_q;

    // Per-component select between new and old vector contents
    generate
        for (genvar k = 0; k < 4; k++) begin : g_merge
            assign w_merged[k*COMP_W +: COMP_W] = I_MW_CompMask[k] ?
                I_MW_VecData[k*COMP_W +: COMP_W] : I_MW_VecOld[k*COMP_W +: COMP_W];
        end
    endgenerate

    // Classify the scalar result as negative, zero or positive (one-hot)
    always_comb begin
        w_cc = '0;
        if (I_MW_Data[REG_WIDTH-1]) begin
            w_cc[CC_N] = 1'b1;
        end else if (I_MW_Data == '0) begin
            w_cc[CC_Z] = 1'b1;
        end else begin
            w_cc[CC_P] = 1'b1;
        end
    end

    assign w_in = '{dest_reg: I_MW_DestRegIdx, dest_write: I_MW_DestWrite,
                    dest_vreg: I_MW_DestVRegIdx, dest_vwrite: I_MW_DestVWrite,
                    data: I_MW_Data, vec: w_merged, cc: w_cc,
                    cc_wen: I_MW_CCWEn, pc_en: I_MW_PCEn, pc: I_MW_PC};

    // Ready is masked by reset so nothing is accepted into a FIFO being cleared
    assign O_MW_Ready = !w_full && !I_RESET;
    assign w_push     = I_MW_Valid && O_MW_Ready;
    assign w_pop      = w_valid[0] && !I_GPUStallSignal && !I_RESET;

    wb_fifo2 #(
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk_i    (I_CLOCK),
        .rst_i    (I_RESET),
        .push_i   (w_push),
        .data_i   (w_in),
        .pop_i    (w_pop),
        .full_o   (w_full),
        .valid_o  (w_valid),
        .entry0_o (w_head),
        .entry1_o (w_tail)
    );

    // Only the destination fields of the second entry feed the pending mask
    assign w_unused = ^w_tail;

    // Destinations of every buffered entry that will write the register files
    always_comb begin
        O_WBPendMask   = '0;
        O_WBPendVWrite = 1'b0;
        if (w_valid[0] && w_head.dest_write) O_WBPendMask[w_head.dest_reg] = 1'b1;
        if (w_valid[1] && w_tail.dest_write) O_WBPendMask[w_tail.dest_reg] = 1'b1;
        O_WBPendVWrite = (w_valid[0] && w_head.dest_vwrite) ||
                         (w_valid[1] && w_tail.dest_vwrite);
    end

    // Retire the head into the output registers; enables pulse for one cycle
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            regidx_q  <= '0;
            data_q    <= '0;
            regwen_q  <= 1'b0;
            vregidx_q <= '0;
            vec_q     <= '0;
            vregwen_q <= 1'b0;
            cc_q      <= '0;
            ccwen_q   <= 1'b0;
            pc_q      <= '0;
            pcen_q    <= 1'b0;
            count_q   <= '0;
        end else if (w_pop) begin
            regidx_q  <= w_head.dest_reg;
            data_q    <= w_head.data;
            regwen_q  <= w_head.dest_write;
            vregidx_q <= w_head.dest_vreg;
            vec_q     <= w_head.vec;
            vregwen_q <= w_head.dest_vwrite;
            cc_q      <= w_head.cc;
            ccwen_q   <= w_head.cc_wen;
            pc_q      <= w_head.pc;
            pcen_q    <= w_head.pc_en;
            count_q   <= count_q + 32'd1;
        end else begin
            regwen_q  <= 1'b0;
            vregwen_q <= 1'b0;
            ccwen_q   <= 1'b0;
            pcen_q    <= 1'b0;
        end
    end

    assign O_WriteBackRegIdx  = regidx_q;
    assign O_WriteBackData    = data_q;
    assign O_RegWEn           = regwen_q;
    assign O_WriteBackVRegIdx = vregidx_q;
    assign O_VecDestValue     = vec_q;
    assign O_VRegWEn          = vregwen_q;
    assign O_CCValue          = cc_q;
    assign O_CCWEn            = ccwen_q;
    assign O_WriteBackPC      = pc_q;
    assign O_WriteBackPCEn    = pcen_q;
    assign O_RetireCount      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// =============================================================================
// Module      : tb_wb_stage
// Description : Bench for wb_stage. A queue-based model of the writeback
//               buffer predicts every output; directed scenarios are followed
//               by a randomized traffic phase with stalls and resets.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, stall;
    logic [3:0]  rd;
    logic        rw;
    logic [2:0]  vd;
    logic        vw;
    logic [15:0] data;
    logic [63:0] vdata, vold;
    logic [3:0]  cmask;
    logic        ccw, pcen;
    logic [15:0] pc;

    logic        ready;
    logic [3:0]  o_rd;
    logic [15:0] o_data;
    logic        o_rw;
    logic [2:0]  o_vd;
    logic [63:0] o_vec;
    logic        o_vw;
    logic [2:0]  o_cc;
    logic        o_ccw;
    logic [15:0] o_pc;
    logic        o_pcen;
    logic [15:0] o_mask;
    logic        o_pendv;
    logic [31:0] o_cnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .I_CLOCK            (clk),
        .I_RESET            (rst),
        .I_MW_Valid         (valid),
        .O_MW_Ready         (ready),
        .I_MW_DestRegIdx    (rd),
        .I_MW_DestWrite     (rw),
        .I_MW_DestVRegIdx   (vd),
        .I_MW_DestVWrite    (vw),
        .I_MW_Data          (data),
        .I_MW_VecData       (vdata),
        .I_MW_VecOld        (vold),
        .I_MW_CompMask      (cmask),
        .I_MW_CCWEn         (ccw),
        .I_MW_PCEn          (pcen),
        .I_MW_PC            (pc),
        .I_GPUStallSignal   (stall),
        .O_WriteBackRegIdx  (o_rd),
        .O_WriteBackData    (o_data),
        .O_RegWEn           (o_rw),
        .O_WriteBackVRegIdx (o_vd),
        .O_VecDestValue     (o_vec),
        .O_VRegWEn          (o_vw),
        .O_CCValue          (o_cc),
        .O_CCWEn            (o_ccw),
        .O_WriteBackPC      (o_pc),
        .O_WriteBackPCEn    (o_pcen),
        .O_WBPendMask       (o_mask),
        .O_WBPendVWrite     (o_pendv),
        .O_RetireCount      (o_cnt)
    );

    typedef struct {
        logic [3:0]  rd;
        logic        rw;
        logic [2:0]  vd;
        logic        vw;
        logic [15:0] data;
        logic [63:0] vec;
        logic [2:0]  cc;
        logic        ccw;
        logic        pcen;
        logic [15:0] pc;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    logic        e_rw, e_vw, e_ccw, e_pcen;
    logic [31:0] e_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bundle as the stage should remember it, derived from the input rules
    function automatic ent_t capture();
        ent_t e;
        e.rd = rd; e.rw = rw; e.vd = vd; e.vw = vw; e.data = data;
        e.ccw = ccw; e.pcen = pcen; e.pc = pc;
        for (int k = 0; k < 4; k++)
            e.vec[16*k +: 16] = cmask[k] ? vdata[16*k +: 16] : vold[16*k +: 16];
        if ($signed(data) < 0)  e.cc = 3'b100;
        else if (data == 16'd0) e.cc = 3'b010;
        else                    e.cc = 3'b001;
        return e;
    endfunction

    // One clock: pre-edge combinational checks, model step, post-edge checks
    task automatic cycle();
        bit          ret, acc;
        ent_t        e;
        logic [15:0] m;
        logic        pv;
        @(negedge clk);
        m = '0; pv = 1'b0;
        foreach (q[i]) begin
            if (q[i].rw) m[q[i].rd] = 1'b1;
            if (q[i].vw) pv = 1'b1;
        end
        check("ready", {63'd0, ready}, {63'd0, (!rst && q.size() < 2)});
        check("pend_mask", {48'd0, o_mask}, {48'd0, m});
        check("pend_vwrite", {63'd0, o_pendv}, {63'd0, pv});
        ret = !rst && q.size() > 0 && !stall;
        acc = !rst && valid && q.size() < 2;
        e   = capture();
        @(posedge clk);
        if (rst) begin
            q.delete();
            last = '{default: '0};
            {e_rw, e_vw, e_ccw, e_pcen} = 4'b0;
            e_cnt = 0;
        end else begin
            if (ret) begin
                last = q.pop_front();
                e_rw = last.rw; e_vw = last.vw; e_ccw = last.ccw; e_pcen = last.pcen;
                e_cnt = e_cnt + 1;
            end else begin
                {e_rw, e_vw, e_ccw, e_pcen} = 4'b0;
            end
            if (acc) q.push_back(e);
        end
        #1;
        check("regwen", {63'd0, o_rw}, {63'd0, e_rw});
        check("vregwen", {63'd0, o_vw}, {63'd0, e_vw});
        check("ccwen", {63'd0, o_ccw}, {63'd0, e_ccw});
        check("pcen", {63'd0, o_pcen}, {63'd0, e_pcen});
        check("regidx", {60'd0, o_rd}, {60'd0, last.rd});
        check("wbdata", {48'd0, o_data}, {48'd0, last.data});
        check("vregidx", {61'd0, o_vd}, {61'd0, last.vd});
        check("vecval", o_vec, last.vec);
        check("ccvalue", {61'd0, o_cc}, {61'd0, last.cc});
        check("wbpc", {48'd0, o_pc}, {48'd0, last.pc});
        check("retire_cnt", {32'd0, o_cnt}, {32'd0, e_cnt});
    endtask

    task automatic bundle(input logic [3:0] r, input logic w, input logic [15:0] d,
                          input logic cw, input logic pe, input logic [15:0] p);
        valid = 1'b1; rd = r; rw = w; data = d; ccw = cw; pcen = pe; pc = p;
        vd = 3'd0; vw = 1'b0; vdata = '0; vold = '0; cmask = 4'h0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; stall = 1'b0;
        bundle(4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);
        valid = 1'b0;
        last = '{default: '0};
        {e_rw, e_vw, e_ccw, e_pcen} = 4'b0;
        e_cnt = 0;
        repeat (2) @(posedge clk);
        cycle();
        rst = 1'b0;

        // Single ADD with negative result
        bundle(4'd3, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'd0);
        cycle();
        valid = 1'b0;
        cycle();
        check("add_cc", {61'd0, o_cc}, 64'd4);
        check("add_idx", {60'd0, o_rd}, 64'd3);
        cycle();
        check("add_pulse_gone", {60'd0, o_rw, o_vw, o_ccw, o_pcen}, 64'd0);

        // Partial vector write
        bundle(4'd0, 1'b0, 16'd5, 1'b0, 1'b0, 16'd0);
        vd = 3'd5; vw = 1'b1; cmask = 4'b0100;
        vold = 64'h0001_0002_0003_0004; vdata = 64'hAAAA_BBBB_CCCC_DDDD;
        cycle();
        valid = 1'b0;
        cycle();
        check("merge_val", o_vec, 64'h0001_BBBB_0003_0004);

        // Three bundles against a stalled, then released, stage
        rst = 1'b1; cycle(); rst = 1'b0;
        stall = 1'b1;
        bundle(4'd1, 1'b1, 16'd1, 1'b0, 1'b0, 16'd0); cycle();
        bundle(4'd2, 1'b1, 16'd2, 1'b0, 1'b0, 16'd0); cycle();
        bundle(4'd3, 1'b1, 16'd3, 1'b0, 1'b0, 16'd0); cycle();
        check("stall_mask", {48'd0, o_mask}, 64'h6);
        check("stall_ready", {63'd0, ready}, 64'd0);
        stall = 1'b0;
        cycle();
        cycle();
        valid = 1'b0;
        repeat (2) cycle();
        check("stall_count", {32'd0, o_cnt}, 64'd3);

        // Branch redirect, then zero result
        bundle(4'd7, 1'b0, 16'd9, 1'b0, 1'b1, 16'h0040); cycle();
        bundle(4'd4, 1'b1, 16'd0, 1'b1, 1'b0, 16'd0);    cycle();
        check("branch_pc", {47'd0, o_pc, o_pcen}, {47'd0, 16'h0040, 1'b1});
        valid = 1'b0;
        cycle();
        check("zero_cc", {61'd0, o_cc}, 64'd2);
        cycle();

        // Reset while full and stalled
        stall = 1'b1;
        bundle(4'd8, 1'b1, 16'd8, 1'b1, 1'b0, 16'd0); cycle();
        bundle(4'd9, 1'b1, 16'd9, 1'b1, 1'b1, 16'd1); cycle();
        rst = 1'b1; valid = 1'b0; cycle();
        check("rst_mask", {48'd0, o_mask}, 64'd0);
        check("rst_count", {32'd0, o_cnt}, 64'd0);
        rst = 1'b0; stall = 1'b0;
        repeat (3) cycle();

        // Randomized traffic with stalls and occasional resets
        for (int n = 0; n < 400; n++) begin
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            rd = 4'($urandom); rw = 1'($urandom); vd = 3'($urandom); vw = 1'($urandom);
            data  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            vdata = {$urandom, $urandom}; vold = {$urandom, $urandom};
            cmask = 4'($urandom); ccw = 1'($urandom); pcen = 1'($urandom); pc = 16'($urandom);
            cycle();
        end
        rst = 1'b0; stall = 1'b0; valid = 1'b0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
